// File: rtl/addsub_multicycle_if.sv
// Operand/result bundle between the calculator control FSM (master) and the
// multi-cycle adder/subtractor (slave).
//
// Handshake: the master raises i_start with i_mode/i_A/i_B/i_Cin valid; the
// slave samples them only while idle or in its done cycle. o_busy is high
// while the operation ripples. o_done pulses for one cycle when o_sum,
// o_carry, o_overflow and o_zero have been committed, and those results hold
// until the next commit. i_start while busy is ignored.
interface addsub_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_Cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_start, i_mode, i_A, i_B, i_Cin,
    input  o_busy, o_done, o_sum, o_carry, o_overflow, o_zero
  );

  modport slave (
    input  i_start, i_mode, i_A, i_B, i_Cin,
    output o_busy, o_done, o_sum, o_carry, o_overflow, o_zero
  );
endinterface

// File: rtl/addsub_multicycle.sv
// Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit ripple chain is reused
// NSLICE times; the carry between slices lives in carry_q. Subtract is done
// as A + ~B + ~Cin, so o_carry = 1 means "no borrow" in subtract mode.
// The operand registers shift right by SLICE each RUN cycle so the active
// slice is always the low SLICE bits; the result register fills from the top.
module addsub_multicycle #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  addsub_multicycle_if.slave  bus,
  output logic [1:0]          o_dbg_state
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] b_in;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_d;
  logic             accept;

  // Slice adder and the result register with the new slice shifted in at the top.
  always_comb begin
    b_in      = bus.i_mode ? ~bus.i_B : bus.i_B;
    slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
              + {{SLICE{1'b0}}, carry_q};
    res_d     = WIDTH'({slice_sum[SLICE-1:0], res_q} >> SLICE);
    accept    = bus.i_start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (accept) begin
      // Same capture from IDLE and from DONE, giving back-to-back launches.
      state_q <= RUN;
      a_q     <= bus.i_A;
      b_q     <= b_in;
      a_msb_q <= bus.i_A[WIDTH-1];
      b_msb_q <= b_in[WIDTH-1];
      carry_q <= bus.i_Cin ^ bus.i_mode;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          carry_q <= slice_sum[SLICE];
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            sum_q       <= res_d;
            carry_out_q <= slice_sum[SLICE];
            ovf_q       <= (a_msb_q == b_msb_q) && (slice_sum[SLICE-1] != a_msb_q);
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_sum      = sum_q;
  assign bus.o_carry    = carry_out_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_zero     = (sum_q == '0);
  assign o_dbg_state    = state_q;
endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: three instances (SLICE = 4, 1, 16) share the
// operand inputs; each has its own start. Expected results come from plain
// integer arithmetic on the operands.
module tb_addsub_multicycle;
  logic clk;
  logic rst;
  logic mode;
  logic cin;
  logic [15:0] a;
  logic [15:0] b;
  logic start_v [3];

  logic        busy_a  [3];
  logic        done_a  [3];
  logic [15:0] sum_a   [3];
  logic        carry_a [3];
  logic        ovf_a   [3];
  logic        zero_a  [3];
  logic [1:0]  st_a    [3];

  int n_vec;
  int n_err;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  addsub_multicycle_if #(.WIDTH(16)) bus0 ();
  addsub_multicycle_if #(.WIDTH(16)) bus1 ();
  addsub_multicycle_if #(.WIDTH(16)) bus2 ();

  addsub_multicycle #(.WIDTH(16), .SLICE(4)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0), .o_dbg_state(st_a[0]));
  addsub_multicycle #(.WIDTH(16), .SLICE(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1), .o_dbg_state(st_a[1]));
  addsub_multicycle #(.WIDTH(16), .SLICE(16)) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2), .o_dbg_state(st_a[2]));

  assign bus0.i_start = start_v[0];
  assign bus1.i_start = start_v[1];
  assign bus2.i_start = start_v[2];
  assign bus0.i_mode = mode;
  assign bus1.i_mode = mode;
  assign bus2.i_mode = mode;
  assign bus0.i_A = a;
  assign bus1.i_A = a;
  assign bus2.i_A = a;
  assign bus0.i_B = b;
  assign bus1.i_B = b;
  assign bus2.i_B = b;
  assign bus0.i_Cin = cin;
  assign bus1.i_Cin = cin;
  assign bus2.i_Cin = cin;

  assign busy_a[0] = bus0.o_busy;
  assign busy_a[1] = bus1.o_busy;
  assign busy_a[2] = bus2.o_busy;
  assign done_a[0] = bus0.o_done;
  assign done_a[1] = bus1.o_done;
  assign done_a[2] = bus2.o_done;
  assign sum_a[0] = bus0.o_sum;
  assign sum_a[1] = bus1.o_sum;
  assign sum_a[2] = bus2.o_sum;
  assign carry_a[0] = bus0.o_carry;
  assign carry_a[1] = bus1.o_carry;
  assign carry_a[2] = bus2.o_carry;
  assign ovf_a[0] = bus0.o_overflow;
  assign ovf_a[1] = bus1.o_overflow;
  assign ovf_a[2] = bus2.o_overflow;
  assign zero_a[0] = bus0.o_zero;
  assign zero_a[1] = bus1.o_zero;
  assign zero_a[2] = bus2.o_zero;

  // Scoreboard: expected results of launched operations, oldest first
  logic [17:0] exp_q [$];

  function automatic int nslice(input int d);
    if (d == 0) return 4;
    if (d == 1) return 16;
    return 1;
  endfunction

  // Reference: {overflow, carry, sum} from integer arithmetic
  function automatic logic [17:0] model(input logic m, input logic [15:0] x,
                                        input logic [15:0] y, input logic c);
    int u;
    int s;
    int sx;
    int sy;
    logic [15:0] r;
    logic co;
    logic v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!m) begin
      u  = int'(x) + int'(y) + int'(c);
      s  = sx + sy + int'(c);
      co = (u > 65535);
    end else begin
      u  = int'(x) - int'(y) - int'(c);
      s  = sx - sy - int'(c);
      co = (u >= 0);
    end
    v = (s > 32767) || (s < -32768);
    r = u[15:0];
    return {v, co, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check($sformatf("%s_busy%0d", tag, d), 32'(busy_a[d]), 32'd0);
    check($sformatf("%s_done%0d", tag, d), 32'(done_a[d]), 32'd0);
    check($sformatf("%s_sum%0d", tag, d), 32'(sum_a[d]), 32'd0);
    check($sformatf("%s_carry%0d", tag, d), 32'(carry_a[d]), 32'd0);
    check($sformatf("%s_ovf%0d", tag, d), 32'(ovf_a[d]), 32'd0);
    check($sformatf("%s_zero%0d", tag, d), 32'(zero_a[d]), 32'd1);
    check($sformatf("%s_state%0d", tag, d), 32'(st_a[d]), 32'd0);
  endtask

  // Called #1 after the accepting edge E0; pops the expected result.
  task automatic wait_check(input int d, input string tag);
    int lat;
    int busy_n;
    logic [17:0] e;
    e = exp_q.pop_front();
    lat = 0;
    busy_n = busy_a[d] ? 1 : 0;
    while (!done_a[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_a[d]) busy_n++;
    end
    check($sformatf("%s_lat%0d", tag, d), 32'(lat), 32'(nslice(d)));
    check($sformatf("%s_busy%0d", tag, d), 32'(busy_n), 32'(nslice(d)));
    check($sformatf("%s_sum%0d", tag, d), 32'(sum_a[d]), 32'(e[15:0]));
    check($sformatf("%s_carry%0d", tag, d), 32'(carry_a[d]), 32'(e[16]));
    check($sformatf("%s_ovf%0d", tag, d), 32'(ovf_a[d]), 32'(e[17]));
    check($sformatf("%s_zero%0d", tag, d), 32'(zero_a[d]), 32'(e[15:0] == 16'h0));
    @(posedge clk);
    #1;
    check($sformatf("%s_pulse%0d", tag, d), 32'(done_a[d]), 32'd0);
    check($sformatf("%s_hold%0d", tag, d), 32'(sum_a[d]), 32'(e[15:0]));
  endtask

  // Driver: one launch on instance d, then wait for and check its result.
  task automatic run_op(input int d, input logic m, input logic [15:0] x,
                        input logic [15:0] y, input logic c, input string tag);
    @(negedge clk);
    mode = m;
    a    = x;
    b    = y;
    cin  = c;
    start_v[d] = 1'b1;
    exp_q.push_back(model(m, x, y, c));
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    wait_check(d, tag);
  endtask

  // Directed vectors: {mode, A, B, Cin, expected ovf, carry, sum}
  logic        dv_m [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] dv_a [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [15:0] dv_b [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  logic [15:0] dv_s [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
  logic        dv_c [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        dv_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int got_k;
    int dones;
    logic [17:0] e;
    n_vec = 0;
    n_err = 0;
    rst  = 1'b1;
    mode = 1'b0;
    cin  = 1'b0;
    a    = '0;
    b    = '0;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;

    // Reset values
    #12;
    for (int d = 0; d < 3; d++) check_reset_outputs(d, "rst");
    @(negedge clk);
    rst = 1'b0;

    // Directed add/subtract vectors on every slice width, against constants
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        mode = dv_m[i];
        a    = dv_a[i];
        b    = dv_b[i];
        cin  = 1'b0;
        start_v[d] = 1'b1;
        exp_q.push_back({dv_v[i], dv_c[i], dv_s[i]});
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        wait_check(d, $sformatf("dir%0d", i));
      end
    end

    // Randomised operations against the arithmetic model
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 15; i++) begin
        run_op(d, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), "rnd");
      end
    end

    // Start/operand noise during RUN, then a back-to-back launch from DONE
    @(negedge clk);
    mode = 1'b0;
    a    = 16'h1111;
    b    = 16'h1111;
    cin  = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    got_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_a[0]) begin
        got_k = k;
        break;
      end
      start_v[0] = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
    end
    check("noise_lat", 32'(got_k), 32'd4);
    check("noise_sum", 32'(sum_a[0]), 32'h2222);
    check("noise_carry", 32'(carry_a[0]), 32'd0);
    a = 16'hA5A5;
    b = 16'h0101;
    start_v[0] = 1'b1;
    exp_q.push_back(model(1'b0, 16'hA5A5, 16'h0101, 1'b0));
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("b2b_busy", 32'(busy_a[0]), 32'd1);
    wait_check(0, "b2b");

    // Asynchronous reset two RUN cycles into an operation
    @(negedge clk);
    mode = 1'b0;
    a    = 16'h1234;
    b    = 16'h4321;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs(0, "arst");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_a[0]) dones++;
    end
    check("arst_nodone", 32'(dones), 32'd0);
    check("arst_sum", 32'(sum_a[0]), 32'd0);
    run_op(0, 1'b1, 16'h0005, 16'h0007, 1'b1, "post");

    // Scoreboard must be drained
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
